riscv_prefetch_ctrl: RTL
========================

Name: riscv_prefetch_ctrl

Overview:
Sequencing controller between the instruction-memory bus and the 4-entry fetch FIFO. It generates word-aligned fetch requests with a req/gnt/rvalid handshake and keeps at most one transaction outstanding. Returned words are pushed into the FIFO with their address. On branches it clears the FIFO and discards in-flight data. On hardware-loop jumps it redirects fetch and marks the target word for second-entry replacement.

Parameters:
ADDR_W, 32, fetch address width; bit 1 selects the halfword, bits 1:0 are never driven onto the bus.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
req_i  input  1  core wants instructions; fetching is enabled while high
branch_i  input  1  single-cycle branch/jump strobe
branch_addr_i  input  ADDR_W  branch target, may be halfword-aligned
hwlp_i  input  1  single-cycle hardware-loop jump strobe
hwlp_target_i  input  ADDR_W  loop start address, word-aligned
instr_req_o  output  1  bus request
instr_addr_o  output  ADDR_W  bus address, bits 1:0 always 00
instr_gnt_i  input  1  bus grant
instr_rvalid_i  input  1  bus read data valid
instr_rdata_i  input  32  bus read data
fifo_valid_o  output  1  push strobe to FIFO
fifo_addr_o  output  ADDR_W  address tagged on the pushed word
fifo_rdata_o  output  32  pushed word, equal to instr_rdata_i
fifo_ready_i  input  1  FIFO can accept a word
fifo_clear_o  output  1  FIFO flush
fifo_replace2_o  output  1  pushed word replaces FIFO entry 1
fifo_is_hwlp_o  output  1  pushed word is a hardware-loop target
busy_o  output  1  transaction outstanding or pending

Behaviour:
- Reset: state IDLE. fetch_addr_Q=0, tag_addr_Q=0, hwlp_pend_Q=0. All outputs 0.
- States and transitions:
  - IDLE: goes to WAIT_GNT when `issue` is high.
  - WAIT_GNT: drives instr_req_o=1 until instr_gnt_i; on grant goes to WAIT_RVALID.
  - WAIT_RVALID: on instr_rvalid_i, pushes the word. Then goes to WAIT_GNT if `issue` is high, otherwise to IDLE.
  - WAIT_ABORTED: entered when branch_i arrives in WAIT_RVALID. The next instr_rvalid_i is dropped (fifo_valid_o=0). Then goes to WAIT_GNT.
- issue = req_i & fifo_ready_i, or a pending redirect.
- Pointer and tag update:
  - instr_addr_o = {fetch_addr_Q[ADDR_W-1:2],2'b00}.
  - On grant: tag_addr_Q <= fetch_addr_Q, and fetch_addr_Q <= aligned(fetch_addr_Q)+4.
  - Wrap-around of fetch_addr_Q at 2^ADDR_W is modulo; no error is flagged.
- Push:
  - fifo_valid_o = instr_rvalid_i & state==WAIT_RVALID & ~branch_i.
  - fifo_addr_o = tag_addr_Q, which keeps bit 1 so the FIFO can serve an unaligned entry.
  - Push latency is zero cycles from rvalid.
- Branch:
  - fifo_clear_o = branch_i, combinational, in the same cycle.
  - fetch_addr_Q <= branch_addr_i, keeping bit 1. The first tag therefore carries the halfword offset; later tags are aligned.
  - Branch in WAIT_GNT: instr_addr_o switches to aligned(branch_addr_i) in that cycle. If instr_gnt_i is also high, the grant applies to the new address.
  - Branch in IDLE: request is issued the next cycle regardless of fifo_ready_i.
  - Branch clears hwlp_pend_Q.
  - branch_i and hwlp_i in the same cycle: branch wins and hwlp_i is ignored.
- Hardware loop:
  - hwlp_i sets hwlp_pend_Q and latches hwlp_target_i. The outstanding transaction is not aborted.
  - The next request issued after that transaction completes uses the target address.
  - When the target word returns: fifo_replace2_o=1 and fifo_is_hwlp_o=1 with fifo_valid_o, and hwlp_pend_Q clears.
  - After a hwloop redirect, fetch continues sequentially from target+4.
- Back-pressure: a new request is never started while fifo_ready_i=0, except for a redirect. This guarantees at most one unaccepted word.
- busy_o = (state != IDLE) | hwlp_pend_Q.
- Reset asserted mid-transaction: state is abandoned. Any later stray rvalid is ignored because state is IDLE.

Optional Feature:
RISCV_PREFETCH_HWLP_EN:
- Defined: hardware-loop redirect logic as above.
- Undefined: hwlp_i and hwlp_target_i are ignored. fifo_replace2_o and fifo_is_hwlp_o are tied to 0, hwlp_pend_Q is removed, and busy_o = state != IDLE.

Test Plan:
- Branch to 0x100, req_i=1, fifo_ready_i=1, gnt same cycle, rvalid next cycle -> instr_addr_o=0x100, then 0x104. Pushes are tagged 0x100 and 0x104, one every 2 cycles.
- Branch to 0x202 -> instr_addr_o=0x200 and first push tagged 0x202; next request 0x204 tagged 0x204.
- Branch to 0x300 while WAIT_RVALID for 0x104 -> fifo_clear_o=1 that cycle. The rvalid for 0x104 produces no push; next request is 0x300.
- hwlp_i with target 0x400 while WAIT_RVALID for 0x108 -> 0x108 is pushed normally. Next request is 0x400, pushed with replace2=1 and is_hwlp=1; then 0x404 is pushed plain.
- fifo_ready_i=0 after a push -> instr_req_o stays 0 and busy_o=0. Raising fifo_ready_i restarts at the next sequential address.
- rst_n pulsed low in WAIT_GNT -> all outputs 0 immediately. A later rvalid is ignored, with no push.

Source files
------------

// File: rtl/riscv_prefetch_ctrl.sv
// riscv_prefetch_ctrl: sequences one-at-a-time word fetches from the
// instruction bus into the fetch FIFO, with branch flush and hw-loop redirect.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   req_i                 fetch enable from the core
//   branch_i/_addr_i      branch strobe and target (halfword aligned allowed)
//   hwlp_i/_target_i      hw-loop jump strobe and word-aligned loop start
//   instr_req_o/addr_o    bus request and word-aligned address
//   instr_gnt_i/rvalid_i  bus grant and read-data valid
//   instr_rdata_i         bus read data
//   fifo_valid_o          push strobe, fifo_addr_o/fifo_rdata_o pushed entry
//   fifo_ready_i          FIFO can take a word
//   fifo_clear_o          FIFO flush (mirrors branch_i)
//   fifo_replace2_o       pushed word replaces FIFO entry 1
//   fifo_is_hwlp_o        pushed word is a hw-loop target
//   busy_o                transaction outstanding or redirect pending
//
// Build option: define RISCV_PREFETCH_HWLP_EN to enable the hw-loop redirect;
// without it hwlp_i/hwlp_target_i are ignored and the hwlp flags stay 0.

module riscv_prefetch_ctrl #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] branch_addr_i,
    input  logic              hwlp_i,
    input  logic [ADDR_W-1:0] hwlp_target_i,
    output logic              instr_req_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    input  logic              instr_gnt_i,
    input  logic              instr_rvalid_i,
    input  logic [31:0]       instr_rdata_i,
    output logic              fifo_valid_o,
    output logic [ADDR_W-1:0] fifo_addr_o,
    output logic [31:0]       fifo_rdata_o,
    input  logic              fifo_ready_i,
    output logic              fifo_clear_o,
    output logic              fifo_replace2_o,
    output logic              fifo_is_hwlp_o,
    output logic              busy_o
);

    localparam logic [1:0] S_IDLE         = 2'd0;
    localparam logic [1:0] S_WAIT_GNT     = 2'd1;
    localparam logic [1:0] S_WAIT_RVALID  = 2'd2;
    localparam logic [1:0] S_WAIT_ABORTED = 2'd3;

    localparam logic [ADDR_W-1:0] WORD = ADDR_W'(4);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [ADDR_W-1:0] r_fetch_addr;
    logic [ADDR_W-1:0] r_tag_addr;

    logic [ADDR_W-1:0] w_fetch_al;
    logic [ADDR_W-1:0] w_branch_al;
    logic [ADDR_W-1:0] w_redir_addr;
    logic              w_req;
    logic              w_grant;
    logic              w_push;
    logic              w_issue;
    logic              w_start;
    logic              w_redir;
    logic              w_hwlp_tag;
    logic              w_hwlp_busy;

    assign w_fetch_al  = {r_fetch_addr[ADDR_W-1:2], 2'b00};
    assign w_branch_al = {branch_addr_i[ADDR_W-1:2], 2'b00};

    assign w_req   = (r_state == S_WAIT_GNT);
    assign w_grant = w_req & instr_gnt_i;
    assign w_push  = instr_rvalid_i & (r_state == S_WAIT_RVALID) & ~branch_i;
    assign w_issue = (req_i & fifo_ready_i) | w_redir;

    // A fresh request is being opened this cycle (not a branch restart).
    assign w_start = (r_state != S_WAIT_GNT)
                   & (w_state_nxt == S_WAIT_GNT)
                   & ~branch_i;

`ifdef RISCV_PREFETCH_HWLP_EN
    logic              r_hwlp_pend;
    logic              r_hwlp_infl;
    logic [ADDR_W-1:0] r_hwlp_addr;
    logic              w_hwlp_new;

    assign w_hwlp_new   = hwlp_i & ~branch_i;
    // Redirect when a jump arrives now or one is waiting and its target
    // has not been requested yet.
    assign w_redir      = w_hwlp_new | (r_hwlp_pend & ~r_hwlp_infl);
    assign w_redir_addr = w_hwlp_new ? hwlp_target_i : r_hwlp_addr;
    assign w_hwlp_tag   = r_hwlp_infl;
    assign w_hwlp_busy  = r_hwlp_pend;

    // r_hwlp_infl: the open transaction is the loop-target fetch.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hwlp_pend <= 1'b0;
            r_hwlp_infl <= 1'b0;
            r_hwlp_addr <= '0;
        end else if (branch_i) begin
            r_hwlp_pend <= 1'b0;
            r_hwlp_infl <= 1'b0;
        end else if (hwlp_i) begin
            r_hwlp_pend <= 1'b1;
            r_hwlp_addr <= hwlp_target_i;
            r_hwlp_infl <= w_start;
        end else if (w_push & r_hwlp_infl) begin
            r_hwlp_pend <= 1'b0;
            r_hwlp_infl <= 1'b0;
        end else if (w_start & w_redir) begin
            r_hwlp_infl <= 1'b1;
        end
    end
`else
    logic w_unused_hwlp;

    assign w_unused_hwlp = ^{hwlp_i, hwlp_target_i};
    assign w_redir       = 1'b0;
    assign w_redir_addr  = '0;
    assign w_hwlp_tag    = 1'b0;
    assign w_hwlp_busy   = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (branch_i | w_issue)
                    w_state_nxt = S_WAIT_GNT;
            end
            S_WAIT_GNT: begin
                if (instr_gnt_i)
                    w_state_nxt = S_WAIT_RVALID;
            end
            S_WAIT_RVALID: begin
                // Branch with the data beat: the beat is dropped by the
                // push gate and there is nothing left to abort.
                if (instr_rvalid_i)
                    w_state_nxt = (branch_i | w_issue) ? S_WAIT_GNT
                                                       : S_IDLE;
                else if (branch_i)
                    w_state_nxt = S_WAIT_ABORTED;
            end
            S_WAIT_ABORTED: begin
                if (instr_rvalid_i)
                    w_state_nxt = S_WAIT_GNT;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_fetch_addr <= '0;
            r_tag_addr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                // Grant in a branch cycle belongs to the branch target.
                if (branch_i) begin
                    r_tag_addr   <= branch_addr_i;
                    r_fetch_addr <= w_branch_al + WORD;
                end else begin
                    r_tag_addr   <= r_fetch_addr;
                    r_fetch_addr <= w_fetch_al + WORD;
                end
            end else if (branch_i) begin
                r_fetch_addr <= branch_addr_i;
            end else if (w_start & w_redir) begin
                r_fetch_addr <= w_redir_addr;
            end
        end
    end

    assign instr_req_o     = w_req;
    assign instr_addr_o    = (w_req & branch_i) ? w_branch_al : w_fetch_al;
    assign fifo_valid_o    = w_push;
    assign fifo_addr_o     = r_tag_addr;
    assign fifo_rdata_o    = instr_rdata_i;
    assign fifo_clear_o    = branch_i;
    assign fifo_replace2_o = w_push & w_hwlp_tag;
    assign fifo_is_hwlp_o  = w_push & w_hwlp_tag;
    assign busy_o          = (r_state != S_IDLE) | w_hwlp_busy;

endmodule
